// File: rtl/bcd_serial_converter.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3, one step per clock).
// Latency 8 cycles from accepted start to result; start is ignored while busy.
module bcd_serial_converter (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    // {hundreds, tens, units scratch nibbles, operand} shifted as one register
    logic [19:0] dd_q, dd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  hun_q, hun_d;
    logic [3:0]  ten_q, ten_d;
    logic [3:0]  uni_q, uni_d;

    logic [11:0] adj;
    logic [19:0] step;

    function automatic logic [3:0] adj_nib(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        adj  = {adj_nib(dd_q[19:16]), adj_nib(dd_q[15:12]), adj_nib(dd_q[11:8])};
        step = {adj, dd_q[7:0]} << 1;

        state_d = state_q;
        dd_d    = dd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        uni_d   = uni_q;

        case (state_q)
            CONV: begin
                dd_d  = step;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hun_d   = step[19:16];
                    ten_d   = step[15:12];
                    uni_d   = step[11:8];
                end
            end
            IDLE, DONE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    state_d = CONV;
                    dd_d    = {12'd0, value};
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            dd_q    <= 20'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hun_q   <= 4'd0;
            ten_q   <= 4'd0;
            uni_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dd_q    <= dd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            uni_q   <= uni_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hundreds = hun_q;
    assign tens     = ten_q;
    assign units    = uni_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Bench for bcd_serial_converter: cycle-level reference model plus literal checks.
module tb_bcd_serial_converter;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: remaining cycles of the conversion in flight and last result
    int m_cnt  = 0;
    int m_val  = 0;
    int m_done = 0;
    int m_h    = 0;
    int m_t    = 0;
    int m_u    = 0;

    bcd_serial_converter dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_cnt = 0; m_val = 0; m_done = 0;
            m_h = 0; m_t = 0; m_u = 0;
        end else if (m_cnt == 0) begin
            m_done = 0;
            if (start === 1'b1) begin
                m_cnt = 8;
                m_val = int'(value);
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1;
                m_h = m_val / 100;
                m_t = (m_val / 10) % 10;
                m_u = m_val % 10;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            chk("model_busy", {31'd0, busy}, (m_cnt != 0) ? 1 : 0);
            chk("model_done", {31'd0, done}, m_done);
            chk("model_hundreds", {28'd0, hundreds}, m_h);
            chk("model_tens", {28'd0, tens}, m_t);
            chk("model_units", {28'd0, units}, m_u);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Launch a conversion from IDLE/DONE and check it against hand-computed digits
    task automatic conv_lit(input logic [7:0] v, input int ph, input int pt, input int pu,
                            input int eh, input int et, input int eu,
                            input int hold, input logic [7:0] noise);
        start = 1'b1;
        value = v;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("lit_busy", {31'd0, busy}, 1);
            chk("lit_done_early", {31'd0, done}, 0);
            chk("lit_hold_hundreds", {28'd0, hundreds}, ph);
            chk("lit_hold_tens", {28'd0, tens}, pt);
            chk("lit_hold_units", {28'd0, units}, pu);
            start = (k < hold);
            value = noise;
            tick();
        end
        chk("lit_busy_end", {31'd0, busy}, 0);
        chk("lit_done", {31'd0, done}, 1);
        chk("lit_hundreds", {28'd0, hundreds}, eh);
        chk("lit_tens", {28'd0, tens}, et);
        chk("lit_units", {28'd0, units}, eu);
        start = 1'b0;
        tick();
        chk("lit_done_single", {31'd0, done}, 0);
        chk("lit_busy_after", {31'd0, busy}, 0);
        chk("lit_keep_units", {28'd0, units}, eu);
    endtask

    initial begin
        int last_done;
        start  = 1'b0;
        value  = 8'd0;
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_hundreds", {28'd0, hundreds}, 0);
        chk("rst_tens", {28'd0, tens}, 0);
        chk("rst_units", {28'd0, units}, 0);
        resetn = 1'b1;

        conv_lit(8'd0,   0, 0, 0, 0, 0, 0, 0, 8'd77);
        conv_lit(8'd255, 0, 0, 0, 2, 5, 5, 0, 8'd13);
        chk("model_pin_h255", m_h, 2);
        chk("model_pin_t255", m_t, 5);
        chk("model_pin_u255", m_u, 5);
        conv_lit(8'd99,  2, 5, 5, 0, 9, 9, 4, 8'd200);
        conv_lit(8'd58,  0, 9, 9, 0, 5, 8, 0, 8'd3);
        repeat (20) tick();
        chk("idle_hold_hundreds", {28'd0, hundreds}, 0);
        chk("idle_hold_tens", {28'd0, tens}, 5);
        chk("idle_hold_units", {28'd0, units}, 8);
        conv_lit(8'd7,   0, 5, 8, 0, 0, 7, 0, 8'd250);
        chk("model_pin_u7", m_u, 7);

        // Asynchronous reset in the middle of a conversion
        start = 1'b1;
        value = 8'd137;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #1 resetn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_hundreds", {28'd0, hundreds}, 0);
        chk("arst_tens", {28'd0, tens}, 0);
        chk("arst_units", {28'd0, units}, 0);
        tick();
        resetn = 1'b1;
        conv_lit(8'd42,  0, 0, 0, 0, 4, 2, 0, 8'd137);

        // Exhaustive sweep with back-to-back starts issued in DONE
        last_done = 0;
        start = 1'b1;
        value = 8'd0;
        tick();
        for (int v = 0; v < 256; v++) begin
            for (int k = 0; k < 8; k++) begin
                value = 8'($urandom);
                tick();
            end
            chk("sweep_done", {31'd0, done}, 1);
            chk("sweep_hundreds", {28'd0, hundreds}, v / 100);
            chk("sweep_tens", {28'd0, tens}, (v / 10) % 10);
            chk("sweep_units", {28'd0, units}, v % 10);
            if (v > 0) chk("sweep_spacing", cyc - last_done, 9);
            last_done = cyc;
            value = 8'(v + 1);
            start = (v < 255);
            tick();
        end
        start = 1'b0;
        repeat (3) tick();

        // Random start/value traffic, checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 2) == 0);
            value = 8'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
